// File: rtl/eth_rx_addr_filter_pkg.sv
// eth_filter_pkg: shared constants for the receive destination-address filter.
//   - FSM state encoding (HDR, FLUSH, PASS, DROP)
//   - HDR_BYTES      : number of destination-address bytes buffered per frame
//   - MAC_BROADCAST  : all-ones broadcast address
//   - addr_match()   : forward/discard decision for a complete destination address
package eth_filter_pkg;

    localparam int          HDR_BYTES     = 6;
    localparam logic [2:0]  LAST_HDR_IDX  = 3'd5;
    localparam logic [47:0] MAC_BROADCAST = 48'hFFFF_FFFF_FFFF;

    localparam logic [1:0] ST_HDR   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_PASS  = 2'd2;
    localparam logic [1:0] ST_DROP  = 2'd3;

    // Forward when promiscuous, unicast hit, broadcast, or group address with multicast enabled.
    // The group bit is bit 0 of the first byte on the wire, i.e. dest[40].
    function automatic logic addr_match(
        input logic [47:0] dest,
        input logic [47:0] station,
        input logic        promisc,
        input logic        multicast_en
    );
        addr_match = promisc
                   | (dest == station)
                   | (dest == MAC_BROADCAST)
                   | (multicast_en & dest[40]);
    endfunction

endpackage

// File: rtl/eth_rx_addr_filter_if.sv
// eth_rx_addr_filter_if: 8-bit AXI-Stream link used on both sides of the filter.
//   tdata[7:0], tvalid, tready, tlast, tuser (bad-frame flag)
//   master modport drives data/valid/last/user and observes ready;
//   slave modport observes data/valid/last/user and drives ready.
interface eth_rx_addr_filter_if;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/eth_rx_addr_filter.sv
// eth_rx_addr_filter: destination-MAC filter on the 8-bit receive stream.
// Buffers the 6 destination bytes of each frame, decides forward/discard on the
// 6th byte, replays the buffered header, then passes the rest of the frame
// through combinationally. Forwarded and discarded frames are counted.
// Ports:
//   clock125          stream clock
//   resetn            asynchronous active-low reset
//   mac_addr[47:0]    station address, [47:40] is the first byte on the wire
//   promiscuous       forward every frame of at least 6 bytes
//   accept_multicast  forward frames with the group bit set
//   s_axis            input stream from the MAC (slave)
//   m_axis            filtered output stream (master)
//   frames_accepted   forwarded-frame counter (wraps)
//   frames_dropped    discarded-frame counter, runts included (wraps)
module eth_rx_addr_filter
    import eth_filter_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                  clock125,
    input  logic                  resetn,
    input  logic [47:0]           mac_addr,
    input  logic                  promiscuous,
    input  logic                  accept_multicast,
    eth_rx_addr_filter_if.slave   s_axis,
    eth_rx_addr_filter_if.master  m_axis,
    output logic [CNT_WIDTH-1:0]  frames_accepted,
    output logic [CNT_WIDTH-1:0]  frames_dropped
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           state_r;
    logic [2:0]           idx_r;
    logic [2:0]           fidx_r;
    logic [7:0]           hdr_buf_r [0:HDR_BYTES-1];
    logic                 last6_r;
    logic                 user6_r;
    logic                 ready_en_r;
    logic [CNT_WIDTH-1:0] acc_cnt_r;
    logic [CNT_WIDTH-1:0] drop_cnt_r;

    logic [1:0]  state_nxt_s;
    logic        s_tready_s;
    logic        m_tvalid_s;
    logic [7:0]  m_tdata_s;
    logic        m_tlast_s;
    logic        m_tuser_s;
    logic        s_hs_s;
    logic        m_hs_s;
    logic        match_s;
    logic        acc_evt_s;
    logic        drop_evt_s;
    logic [47:0] dest_s;

    // The 6th byte completes the address directly from the input bus, so the
    // decision is available on the same beat it arrives.
    assign dest_s  = {hdr_buf_r[0], hdr_buf_r[1], hdr_buf_r[2],
                      hdr_buf_r[3], hdr_buf_r[4], s_axis.tdata};
    assign match_s = addr_match(dest_s, mac_addr, promiscuous, accept_multicast);
    assign s_hs_s  = s_axis.tvalid & s_tready_s;
    assign m_hs_s  = m_tvalid_s & m_axis.tready;

    // Per-state stream muxing; PASS is a zero-latency combinational path.
    always_comb begin
        s_tready_s = 1'b0;
        m_tvalid_s = 1'b0;
        m_tdata_s  = 8'h00;
        m_tlast_s  = 1'b0;
        m_tuser_s  = 1'b0;
        case (state_r)
            ST_HDR: begin
                // ready_en_r holds ready low until the first edge after reset release
                s_tready_s = ready_en_r;
            end
            ST_FLUSH: begin
                m_tvalid_s = 1'b1;
                m_tdata_s  = hdr_buf_r[fidx_r];
                m_tlast_s  = (fidx_r == LAST_HDR_IDX) & last6_r;
                m_tuser_s  = (fidx_r == LAST_HDR_IDX) & user6_r;
            end
            ST_PASS: begin
                s_tready_s = m_axis.tready;
                m_tvalid_s = s_axis.tvalid;
                m_tdata_s  = s_axis.tdata;
                m_tlast_s  = s_axis.tlast;
                m_tuser_s  = s_axis.tuser;
            end
            ST_DROP: begin
                s_tready_s = 1'b1;
            end
            default: begin
                s_tready_s = 1'b0;
            end
        endcase
    end

    // Next-state decision and end-of-frame events (at most one per cycle).
    always_comb begin
        state_nxt_s = state_r;
        acc_evt_s   = 1'b0;
        drop_evt_s  = 1'b0;
        case (state_r)
            ST_HDR: begin
                if (s_hs_s && (idx_r == LAST_HDR_IDX)) begin
                    if (match_s) begin
                        state_nxt_s = ST_FLUSH;
                    end else if (s_axis.tlast) begin
                        drop_evt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_DROP;
                    end
                end else if (s_hs_s && s_axis.tlast) begin
                    drop_evt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
            ST_FLUSH: begin
                if (m_hs_s && (fidx_r == LAST_HDR_IDX)) begin
                    if (last6_r) begin
                        state_nxt_s = ST_HDR;
                        acc_evt_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_PASS;
                    end
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            ST_PASS: begin
                if (s_hs_s && s_axis.tlast) begin
                    state_nxt_s = ST_HDR;
                    acc_evt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_PASS;
                end
            end
            ST_DROP: begin
                if (s_hs_s && s_axis.tlast) begin
                    state_nxt_s = ST_HDR;
                    drop_evt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_HDR;
            end
        endcase
    end

    // State register, header buffer and its write/read indices.
    always_ff @(posedge clock125 or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_HDR;
            idx_r   <= 3'd0;
            fidx_r  <= 3'd0;
            last6_r <= 1'b0;
            user6_r <= 1'b0;
            for (int i = 0; i < HDR_BYTES; i++) begin
                hdr_buf_r[i] <= 8'h00;
            end
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_HDR) && s_hs_s) begin
                hdr_buf_r[idx_r] <= s_axis.tdata;
                if (idx_r == LAST_HDR_IDX) begin
                    idx_r   <= 3'd0;
                    last6_r <= s_axis.tlast;
                    user6_r <= s_axis.tuser;
                end else if (s_axis.tlast) begin
                    idx_r <= 3'd0;
                end else begin
                    idx_r <= idx_r + 3'd1;
                end
            end
            if ((state_r == ST_FLUSH) && m_hs_s) begin
                if (fidx_r == LAST_HDR_IDX) begin
                    fidx_r <= 3'd0;
                end else begin
                    fidx_r <= fidx_r + 3'd1;
                end
            end
        end
    end

    // Input-ready enable: low throughout reset, high from the first edge after release.
    always_ff @(posedge clock125 or negedge resetn) begin
        if (!resetn) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Frame counters, wrapping modulo 2^CNT_WIDTH.
    always_ff @(posedge clock125 or negedge resetn) begin
        if (!resetn) begin
            acc_cnt_r  <= {CNT_WIDTH{1'b0}};
            drop_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (acc_evt_s) begin
                acc_cnt_r <= acc_cnt_r + CNT_ONE;
            end
            if (drop_evt_s) begin
                drop_cnt_r <= drop_cnt_r + CNT_ONE;
            end
        end
    end

    assign s_axis.tready   = s_tready_s;
    assign m_axis.tvalid   = m_tvalid_s;
    assign m_axis.tdata    = m_tdata_s;
    assign m_axis.tlast    = m_tlast_s;
    assign m_axis.tuser    = m_tuser_s;
    assign frames_accepted = acc_cnt_r;
    assign frames_dropped  = drop_cnt_r;

endmodule

// File: doc/eth_rx_addr_filter.md
# eth_rx_addr_filter

Destination-MAC filter on the 8-bit receive AXI-Stream, placed directly downstream of the 1G RGMII MAC's RX FIFO output and upstream of the DMA/host RX path. It buffers the 6-byte destination address of each frame and decides to forward or discard the whole frame. Accepted frames are passed through unchanged, including tlast and tuser. Accepted and dropped frames are counted.

## Interface
Parameters:
- CNT_WIDTH, 32, width of the frame counters; counters wrap modulo 2^CNT_WIDTH.

Ports:
- clock125  in  1  stream clock, 125 MHz; all logic is on this clock.
- resetn  in  1  reset, asynchronous, active-low.
- mac_addr  in  48  station address; mac_addr[47:40] is compared against frame byte 0 (first byte on the wire).
- promiscuous  in  1  accept every frame of 6 bytes or more.
- accept_multicast  in  1  accept frames whose byte 0 bit 0 is 1.
- s_axis_tdata / tvalid / tready / tlast / tuser  in/in/out/in/in  8/1/1/1/1  frames from the MAC.
- m_axis_tdata / tvalid / tready / tlast / tuser  out/out/in/out/out  8/1/1/1/1  filtered frames.
- frames_accepted  out  CNT_WIDTH  count of forwarded frames.
- frames_dropped  out  CNT_WIDTH  count of discarded frames, runts included.

## Operation
- State HDR: s_tready=1, m_tvalid=0. Each accepted beat is written to buf[idx], and idx increments (0..5).
  - tlast on a beat with idx<5: runt. frames_dropped++, idx←0, stay in HDR.
  - Beat with idx==5: match is evaluated combinationally on buf[0..4] plus the current byte. Config inputs are sampled on this beat. last6/user6 ← tlast/tuser of this beat. Next state is FLUSH if match, else DROP; if tlast, next state is HDR with frames_dropped++.
- match = promiscuous | (dest==mac_addr) | (dest==48'hFFFF_FFFF_FFFF) | (accept_multicast & byte0[0]).
- State FLUSH: s_tready=0, m_tvalid=1, m_tdata=buf[fidx]. m_tlast=(fidx==5)&last6 and m_tuser=(fidx==5)&user6. fidx increments on m_tready.
  - At fidx==5 with handshake: if last6, go to HDR and frames_accepted++; else go to PASS.
- State PASS: combinational pass-through. m_tvalid=s_tvalid, s_tready=m_tready; tdata, tlast and tuser are wired straight through.
  - A handshake with tlast goes to HDR, frames_accepted++.
- State DROP: s_tready=1, m_tvalid=0. Beats are discarded. tlast goes to HDR, frames_dropped++.
- tuser (bad frame) does not affect filtering; it is forwarded for the downstream stage to act on.
- Counters increment by at most 1 per cycle; only one end-of-frame event occurs per cycle.

## Timing
- Reset (resetn low, asynchronous):
  - state=HDR, idx=fidx=0, counters=0, buffer cleared.
  - m_axis_tvalid=0, m_tlast=0, m_tuser=0.
  - s_axis_tready is forced 0 while resetn is low, then rises to 1 in the first cycle after deassertion.
- Latency: the first output byte is valid in the cycle after the 6th input byte is accepted.
- Flush cost: exactly 6 cycles of input stall when m_tready=1; it stretches with downstream backpressure.
- PASS adds zero latency, with a combinational tvalid/tready path.
- m_tvalid in FLUSH never deasserts before its handshake, and m_tdata stays stable.
- Reset mid-frame discards the frame. The tail of that frame then appears in HDR as a new frame; that is accepted behaviour.

## Structure
- Shared header/package eth_filter_pkg holds:
  - state encoding (HDR, FLUSH, PASS, DROP),
  - HDR_BYTES=6,
  - MAC_BROADCAST=48'hFFFF_FFFF_FFFF.
- The block is a single module. The 6×8 buffer, two 3-bit indices, two flags and the counters are inline; no sub-module.

## Test plan
- mac_addr=02:00:00:00:00:01, promiscuous=0, accept_multicast=0; 64-byte frame to 02:00:00:00:00:01 → all 64 bytes out identical, tlast on byte 64, frames_accepted=1.
- Same config; frame to 02:00:00:00:00:02 followed by frame to FF:FF:FF:FF:FF:FF → first discarded, second forwarded; accepted=1, dropped=1.
- Frame to 01:00:5E:00:00:01 with accept_multicast 0 then 1 → dropped then forwarded; promiscuous=1 forwards a frame to 02:AA:BB:CC:DD:EE.
- 4-byte runt, then exactly 6-byte matching frame with tuser=1 → runt dropped (dropped=1); 6 bytes out with tlast and tuser on byte 6, accepted=1.
- Matching 100-byte frame with random m_tready (50%) and random s_tvalid gaps → byte order and count intact; no output beat is lost or duplicated.
- Assert resetn low during a PASS frame, then send a clean frame → outputs zero during reset, counters 0, clean frame forwarded correctly.
